feed_controller: RTL and testbench
==================================

FEED_CONTROLLER -- requirements
Module: feed_controller

Interface
REQ-001 The block SHALL have parameter CLKS_PER_SEC, default 50000000, clock cycles per one-second tick.
REQ-002 The block SHALL have parameter COOLDOWN_SEC, default 2, lockout seconds after a dispense ends.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; clock and reset are named clk and reset.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 request  input  1  single-cycle feed request pulse (button or scheduler).
REQ-007 portion  input  2  portion select sampled with request: 01 small, 10 medium, 11 large, 00 invalid.
REQ-008 cancel  input  1  level; aborts an active dispense.
REQ-009 feed  output  1  high for the whole dispense; drives motor and feed display.
REQ-010 duration  output  32  dispense length in seconds; 4, 6 or 11; stable while feed is high.
REQ-011 elapsed  output  32  whole seconds completed in the current dispense.
REQ-012 busy  output  1  high in DISPENSE or COOLDOWN.
REQ-013 done  output  1  one-cycle pulse when a dispense completes normally.

Function
REQ-014 The FSM SHALL have states IDLE, DISPENSE, COOLDOWN.
REQ-015 IDLE -> DISPENSE on request with portion != 00 and cancel low; duration latched in the same edge (01->4, 10->6, 11->11).
REQ-016 request with portion 00 SHALL be ignored; state and outputs unchanged.
REQ-017 feed SHALL rise one cycle after the accepted request and equal (state == DISPENSE), registered.
REQ-018 The tick counter SHALL clear on entry to DISPENSE and COOLDOWN, count 0..CLKS_PER_SEC-1, and emit a one-cycle tick on wrap.
REQ-019 In DISPENSE, each tick SHALL increment elapsed; when elapsed reaches duration the FSM SHALL go to COOLDOWN and pulse done in that cycle's transition.
REQ-020 feed SHALL therefore be high for exactly duration*CLKS_PER_SEC cycles.
REQ-021 cancel high in DISPENSE SHALL move to COOLDOWN next edge, feed low, no done pulse.
REQ-022 COOLDOWN SHALL last COOLDOWN_SEC ticks, then return to IDLE; COOLDOWN_SEC = 0 returns after one cycle.
REQ-023 request during DISPENSE or COOLDOWN SHALL be dropped, not queued.
REQ-024 request and cancel in the same IDLE cycle: cancel wins, no start.
REQ-025 duration and elapsed SHALL hold their final values in COOLDOWN and IDLE until the next accepted request; elapsed clears to 0 on accept.
REQ-026 All counters SHALL be 32-bit unsigned, no wrap reachable within legal parameters.

Reset
REQ-027 reset low SHALL force IDLE, feed 0, duration 0, elapsed 0, busy 0, done 0, tick counter 0, immediately and asynchronously.
REQ-028 reset asserted mid-dispense SHALL drop feed without a done pulse; after release the block accepts a request in the first IDLE cycle.

Structure
REQ-029 Shared package SHALL hold the state enum, portion codes and duration constants 4/6/11.
REQ-030 The one-second tick generator SHALL be a sub-module named sec_tick with clk, reset, clear, tick.

Verification (bench uses CLKS_PER_SEC=10, COOLDOWN_SEC=2)
REQ-031 request, portion=01 -> feed high 40 cycles, duration=4, elapsed 0..4, done one pulse, busy low 20 cycles after feed falls.
REQ-032 request, portion=11 -> feed high 110 cycles, duration=11 stable throughout, done once.
REQ-033 cancel at cycle 25 of portion=10 dispense -> feed low next cycle, elapsed=2, no done, 20-cycle cooldown.
REQ-034 request during DISPENSE and during COOLDOWN, and request with portion=00 in IDLE -> all ignored, no restart.
REQ-035 reset pulse at cycle 15 of a dispense -> all outputs 0 at once; new request after release starts a full dispense.
REQ-036 request and cancel same cycle in IDLE -> stays IDLE, feed 0, busy 0.

Source files
------------

// File: rtl/feed_controller_pkg.sv
// Shared types and constants for the feed controller: FSM states, portion codes
// and the dispense length that each portion maps to.
package feed_controller_pkg;

    localparam int COUNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_COOLDOWN = 2'd2
    } feed_state_t;

    localparam logic [1:0] PORTION_NONE   = 2'b00;
    localparam logic [1:0] PORTION_SMALL  = 2'b01;
    localparam logic [1:0] PORTION_MEDIUM = 2'b10;
    localparam logic [1:0] PORTION_LARGE  = 2'b11;

    localparam logic [COUNT_W-1:0] DUR_SMALL  = 32'd4;
    localparam logic [COUNT_W-1:0] DUR_MEDIUM = 32'd6;
    localparam logic [COUNT_W-1:0] DUR_LARGE  = 32'd11;

    // Dispense length in seconds for a portion code; the invalid code maps to 0.
    function automatic logic [COUNT_W-1:0] portion_to_duration(input logic [1:0] portion);
        logic [COUNT_W-1:0] dur;
        case (portion)
            PORTION_SMALL:  dur = DUR_SMALL;
            PORTION_MEDIUM: dur = DUR_MEDIUM;
            PORTION_LARGE:  dur = DUR_LARGE;
            default:        dur = '0;
        endcase
        return dur;
    endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second tick generator: counts 0..CLKS_PER_SEC-1 and flags the last count,
// so the tick is the cycle on which the counter wraps back to 0.
module sec_tick
    import feed_controller_pkg::*;
#(
    parameter int CLKS_PER_SEC = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(CLKS_PER_SEC - 1);

    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg + 1'b1;
        if (clear || (count_reg == LAST_COUNT)) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Not gated by clear so the FSM can use tick to decide clear without a loop.
    assign tick = (count_reg == LAST_COUNT);

endmodule

// File: rtl/feed_controller.sv
// Pet feeder dispense controller: accepts a portion request, runs the motor for
// the portion's length in seconds, then holds off new requests for a cooldown.
module feed_controller
    import feed_controller_pkg::*;
#(
    parameter int CLKS_PER_SEC = 50000000,
    parameter int COOLDOWN_SEC = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                request,
    input  logic [1:0]          portion,
    input  logic                cancel,
    output logic                feed,
    output logic [COUNT_W-1:0]  duration,
    output logic [COUNT_W-1:0]  elapsed,
    output logic                busy,
    output logic                done
);

    localparam logic [COUNT_W-1:0] COOL_LAST =
        (COOLDOWN_SEC == 0) ? '0 : COUNT_W'(COOLDOWN_SEC - 1);

    feed_state_t        state_reg, state_next;
    logic [COUNT_W-1:0] duration_reg, duration_next;
    logic [COUNT_W-1:0] elapsed_reg, elapsed_next;
    logic [COUNT_W-1:0] cool_reg, cool_next;
    logic               feed_reg, feed_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               tick_clear;
    logic               tick;

    sec_tick #(
        .CLKS_PER_SEC (CLKS_PER_SEC)
    ) u_sec_tick (
        .clk   (clk),
        .reset (reset),
        .clear (tick_clear),
        .tick  (tick)
    );

    always_comb begin
        state_next    = state_reg;
        duration_next = duration_reg;
        elapsed_next  = elapsed_reg;
        cool_next     = cool_reg;
        done_next     = 1'b0;
        tick_clear    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Cancel in the same cycle as the request suppresses the start.
                if (request && (portion != PORTION_NONE) && !cancel) begin
                    state_next    = ST_DISPENSE;
                    duration_next = portion_to_duration(portion);
                    elapsed_next  = '0;
                    tick_clear    = 1'b1;
                end
            end

            ST_DISPENSE: begin
                if (tick) begin
                    elapsed_next = elapsed_reg + 1'b1;
                end
                if (cancel) begin
                    state_next = ST_COOLDOWN;
                    cool_next  = '0;
                    tick_clear = 1'b1;
                end else if (tick && ((elapsed_reg + 1'b1) == duration_reg)) begin
                    state_next = ST_COOLDOWN;
                    cool_next  = '0;
                    done_next  = 1'b1;
                    tick_clear = 1'b1;
                end
            end

            ST_COOLDOWN: begin
                if (COOLDOWN_SEC == 0) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    if (cool_reg == COOL_LAST) begin
                        state_next = ST_IDLE;
                    end else begin
                        cool_next = cool_reg + 1'b1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        feed_next = (state_next == ST_DISPENSE);
        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            duration_reg <= '0;
            elapsed_reg  <= '0;
            cool_reg     <= '0;
            feed_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            duration_reg <= duration_next;
            elapsed_reg  <= elapsed_next;
            cool_reg     <= cool_next;
            feed_reg     <= feed_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    assign feed     = feed_reg;
    assign duration = duration_reg;
    assign elapsed  = elapsed_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_feed_controller.sv
// Randomized self-checking bench for feed_controller against a per-cycle
// timeline model derived from portion length, cancel point and cooldown.
module tb_feed_controller;

    localparam int N = 10;
    localparam int C = 2;

    logic        clk;
    logic        reset;
    logic        request;
    logic [1:0]  portion;
    logic        cancel;
    logic        feed;
    logic [31:0] duration;
    logic [31:0] elapsed;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;
    logic [31:0] held_dur;
    logic [31:0] held_el;

    feed_controller #(
        .CLKS_PER_SEC (N),
        .COOLDOWN_SEC (C)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .request  (request),
        .portion  (portion),
        .cancel   (cancel),
        .feed     (feed),
        .duration (duration),
        .elapsed  (elapsed),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_duration(input logic [1:0] p);
        if (p == 2'b01) return 4;
        if (p == 2'b10) return 6;
        if (p == 2'b11) return 11;
        return 0;
    endfunction

    // Issues an accepted request, then checks every cycle of dispense, cooldown
    // and a few idle cycles. cancel_at < 0 means run to completion.
    task automatic run_dispense(input logic [1:0] p, input int cancel_at,
                                input bit drop_reqs, input string tag);
        int d, feed_len, cool_len, total;
        logic [31:0] fin_el, e_el, e_dur;
        logic e_feed, e_busy, e_done;
        d        = model_duration(p);
        feed_len = (cancel_at >= 0) ? cancel_at + 1 : d * N;
        fin_el   = (cancel_at >= 0) ? 32'((cancel_at + 1) / N) : 32'(d);
        cool_len = (C == 0) ? 1 : C * N;
        total    = feed_len + cool_len;
        e_dur    = 32'(d);
        request = 1'b1;
        portion = p;
        cancel  = 1'b0;
        step();
        request = 1'b0;
        for (int i = 0; i < total + 3; i++) begin
            if (i < feed_len) begin
                e_feed = 1'b1; e_busy = 1'b1; e_done = 1'b0; e_el = 32'(i / N);
            end else if (i < total) begin
                e_feed = 1'b0; e_busy = 1'b1; e_el = fin_el;
                e_done = (cancel_at < 0) && (i == feed_len);
            end else begin
                e_feed = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_el = fin_el;
            end
            vectors += 5;
            if (feed !== e_feed) begin
                miscompares++;
                $display("FAIL %s feed cyc %0d got %b want %b", tag, i, feed, e_feed);
            end
            if (busy !== e_busy) begin
                miscompares++;
                $display("FAIL %s busy cyc %0d got %b want %b", tag, i, busy, e_busy);
            end
            if (done !== e_done) begin
                miscompares++;
                $display("FAIL %s done cyc %0d got %b want %b", tag, i, done, e_done);
            end
            if (elapsed !== e_el) begin
                miscompares++;
                $display("FAIL %s elapsed cyc %0d got %0d want %0d", tag, i, elapsed, e_el);
            end
            if (duration !== e_dur) begin
                miscompares++;
                $display("FAIL %s duration cyc %0d got %0d want %0d", tag, i, duration, e_dur);
            end
            cancel  = (i == cancel_at);
            request = drop_reqs && (i < total) && ($urandom_range(0, 3) == 0);
            portion = 2'($urandom);
            step();
        end
        request  = 1'b0;
        cancel   = 1'b0;
        held_dur = e_dur;
        held_el  = fin_el;
        $display("txn %s portion=%0d cancel_at=%0d dur=%0d final_elapsed=%0d", tag, p, cancel_at, d, fin_el);
    endtask

    // Checks that the block sits idle with its held values for a few cycles.
    task automatic expect_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            vectors += 5;
            if (feed !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s flags cyc %0d got feed=%b busy=%b done=%b want 0/0/0", tag, i, feed, busy, done);
            end
            if (duration !== held_dur) begin
                miscompares++;
                $display("FAIL %s duration cyc %0d got %0d want %0d", tag, i, duration, held_dur);
            end
            if (elapsed !== held_el) begin
                miscompares++;
                $display("FAIL %s elapsed cyc %0d got %0d want %0d", tag, i, elapsed, held_el);
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; request = 1'b0; cancel = 1'b0; portion = 2'b00;
        #2;
        vectors += 5;
        if ({feed, busy, done} !== 3'b000 || duration !== 32'd0 || elapsed !== 32'd0) begin
            miscompares++;
            $display("FAIL reset outputs got feed=%b busy=%b done=%b dur=%0d el=%0d want all 0", feed, busy, done, duration, elapsed);
        end
        step();
        step();
        reset = 1'b1;
        held_dur = 32'd0;
        held_el  = 32'd0;
        step();
        expect_idle("reset_idle", 3);
        $display("txn reset checked");
    endtask

    task automatic test_small();
        run_dispense(2'b01, -1, 1'b0, "small");
    endtask

    task automatic test_large();
        run_dispense(2'b11, -1, 1'b0, "large");
    endtask

    task automatic test_cancel();
        run_dispense(2'b10, 25, 1'b0, "cancel25");
    endtask

    task automatic test_dropped_requests();
        run_dispense(2'b01, -1, 1'b1, "drop_reqs");
        request = 1'b1;
        portion = 2'b00;
        step();
        request = 1'b0;
        expect_idle("portion00", 5);
        $display("txn portion00 request ignored");
    endtask

    task automatic test_req_cancel_same();
        request = 1'b1;
        portion = 2'($urandom_range(1, 3));
        cancel  = 1'b1;
        step();
        request = 1'b0;
        cancel  = 1'b0;
        expect_idle("req_cancel", 5);
        $display("txn request+cancel in idle ignored");
    endtask

    task automatic test_reset_mid();
        request = 1'b1;
        portion = 2'b10;
        step();
        request = 1'b0;
        for (int i = 0; i < 15; i++) step();
        #3;
        reset = 1'b0;
        #1;
        vectors += 5;
        if ({feed, busy, done} !== 3'b000 || duration !== 32'd0 || elapsed !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid outputs got feed=%b busy=%b done=%b dur=%0d el=%0d want all 0", feed, busy, done, duration, elapsed);
        end
        held_dur = 32'd0;
        held_el  = 32'd0;
        step();
        reset = 1'b1;
        $display("txn reset mid-dispense");
        run_dispense(2'b11, -1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [1:0] p;
            int d, ca;
            p  = 2'($urandom_range(1, 3));
            d  = model_duration(p);
            ca = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, d * N - 2)) : -1;
            run_dispense(p, ca, 1'($urandom), "random");
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        held_dur    = 32'd0;
        held_el     = 32'd0;
        test_reset();
        test_small();
        test_large();
        test_cancel();
        test_dropped_requests();
        test_req_cancel_same();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
